// File: rtl/posit64_decode_arbiter_if.sv
// Request/result bus for the shared posit64 decoder: N_REQ valid/ready requesters
// feeding one registered, requester-tagged result channel.
interface posit64_decode_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*64-1:0] req_posit;
    logic [N_REQ-1:0]    req_ready;

    logic                out_valid;
    logic                out_ready;
    logic [ID_W-1:0]     out_id;
    logic                out_sign;
    logic signed [63:0]  out_regime;
    logic signed [63:0]  out_exponent;
    logic [63:0]         out_fraction;
    logic [31:0]         decode_count;

    // Requesters and the result consumer.
    modport master (
        output req_valid, req_posit, out_ready,
        input  req_ready, out_valid, out_id, out_sign,
               out_regime, out_exponent, out_fraction, decode_count
    );

    // The arbitrated decoder.
    modport slave (
        input  req_valid, req_posit, out_ready,
        output req_ready, out_valid, out_id, out_sign,
               out_regime, out_exponent, out_fraction, decode_count
    );
endinterface

// File: rtl/posit64_decode_arbiter.sv
// Round-robin sharing of one combinational posit64 decoder among N_REQ requesters;
// the decoded fields land in a single tagged output register with valid/ready drain.
module posit64_decode_arbiter #(
    parameter int N_REQ = 4,
    parameter int ES    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    posit64_decode_arbiter_if.slave  bus
);
    localparam int ID_W = $clog2(N_REQ);

    typedef struct packed {
        logic               sign;
        logic signed [63:0] regime;
        logic signed [63:0] exponent;
        logic [63:0]        fraction;
    } dec_t;

    // exponent is the full scale k*2^ES + e; fraction is left-aligned without the hidden bit.
    function automatic dec_t posit_decode(input logic [63:0] p);
        dec_t               d;
        logic [63:0]        mag;
        logic [62:0]        body;
        logic [62:0]        rest;
        logic               r;
        logic [6:0]         run;
        logic               done;
        logic [63:0]        e;
        logic signed [63:0] k;
        mag  = p[63] ? (~p + 64'd1) : p;
        body = mag[62:0];
        r    = body[62];
        run  = 7'd0;
        done = 1'b0;
        for (int j = 62; j >= 0; j--) begin
            if (!done) begin
                if (body[j] == r) run = run + 7'd1;
                else              done = 1'b1;
            end
        end
        // Drop the regime run and its terminator; anything shifted past the end reads as zero.
        rest = body << (run + 7'd1);
        e = '0;
        for (int j = 0; j < ES; j++) begin
            e = {e[62:0], rest[62-j]};
        end
        k = r ? ($signed({57'd0, run}) - 64'sd1) : -$signed({57'd0, run});
        d.sign     = p[63];
        d.regime   = k;
        d.exponent = (k <<< ES) + $signed(e);
        d.fraction = {rest, 1'b0} << ES;
        return d;
    endfunction

    logic [ID_W-1:0]    rr_ptr;
    logic [31:0]        decode_cnt;
    logic               vld_p1;
    logic [ID_W-1:0]    id_p1;
    logic               sign_p1;
    logic signed [63:0] regime_p1;
    logic signed [63:0] exponent_p1;
    logic [63:0]        fraction_p1;

    logic               free_p0;
    logic               any_p0;
    logic               accept_p0;
    logic [ID_W-1:0]    grant_p0;
    logic [ID_W-1:0]    nxt_ptr_p0;
    logic [63:0]        posit_p0;
    dec_t               dec_p0;

    // Stage p0: arbitration, operand mux and shared decode
    always_comb begin
        free_p0  = !vld_p1 || bus.out_ready;
        any_p0   = 1'b0;
        grant_p0 = '0;
        for (int off = 0; off < N_REQ; off++) begin
            int idx;
            idx = (int'(rr_ptr) + off) % N_REQ;
            if (!any_p0 && bus.req_valid[idx]) begin
                any_p0   = 1'b1;
                grant_p0 = ID_W'(idx);
            end
        end
    end

    assign accept_p0  = free_p0 && any_p0 && !rst;
    assign nxt_ptr_p0 = (grant_p0 == ID_W'(N_REQ - 1)) ? '0 : grant_p0 + ID_W'(1);
    assign posit_p0   = bus.req_posit[int'(grant_p0)*64 +: 64];
    assign dec_p0     = posit_decode(posit_p0);
    assign bus.req_ready = accept_p0 ? (N_REQ'(1) << grant_p0) : '0;

    // Stage p1: tagged result register, pointer and handshake counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            id_p1       <= '0;
            sign_p1     <= 1'b0;
            regime_p1   <= '0;
            exponent_p1 <= '0;
            fraction_p1 <= '0;
            rr_ptr      <= '0;
            decode_cnt  <= '0;
        end else begin
            if (accept_p0) begin
                vld_p1      <= 1'b1;
                id_p1       <= grant_p0;
                sign_p1     <= dec_p0.sign;
                regime_p1   <= dec_p0.regime;
                exponent_p1 <= dec_p0.exponent;
                fraction_p1 <= dec_p0.fraction;
                rr_ptr      <= nxt_ptr_p0;
            end else if (bus.out_ready) begin
                vld_p1 <= 1'b0;
            end
            if (vld_p1 && bus.out_ready) begin
                decode_cnt <= decode_cnt + 32'd1;
            end
        end
    end

    assign bus.out_valid    = vld_p1;
    assign bus.out_id       = id_p1;
    assign bus.out_sign     = sign_p1;
    assign bus.out_regime   = regime_p1;
    assign bus.out_exponent = exponent_p1;
    assign bus.out_fraction = fraction_p1;
    assign bus.decode_count = decode_cnt;
endmodule

// File: doc/posit64_decode_arbiter.md
Name: posit64_decode_arbiter

Overview:
- Shares one combinational posit64_decode instance (parameter es = ES) between N_REQ requesters.
- Each requester presents a 64-bit posit on a valid/ready channel. A round-robin arbiter grants one requester per cycle.
- The decoded fields are captured in a single output register, tagged with the requester ID, and drained on a valid/ready result channel.
- Sits between the posit operand fetch ports and the posit arithmetic units in the decode stage.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- ES, 2, exponent size passed to the shared decoder.
- ID_W, $clog2(N_REQ), width of the requester tag (derived, not overridable).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_posit  in  N_REQ*64  packed posit64_t operands; requester i occupies bits [64*i+63:64*i].
- req_ready  out  N_REQ  per-requester accept; one-hot or zero.
- out_valid  out  1  result register holds a valid result.
- out_ready  in  1  consumer accepts the result.
- out_id  out  ID_W  index of the requester that produced the result.
- out_sign  out  1  decoded sign.
- out_regime  out  64  signed decoded regime.
- out_exponent  out  64  signed decoded exponent.
- out_fraction  out  64  unsigned decoded fraction.
- decode_count  out  32  number of completed output handshakes; wraps.

Behaviour:
- Reset (asynchronous assert, synchronous release on clk) forces:
  - out_valid=0; out_id, out_sign, out_regime, out_exponent, out_fraction all 0;
  - rr_ptr=0; decode_count=0.
  - req_ready is forced to all zeros while rst is high.
- Output register is "free" when out_valid=0, or when out_valid=1 && out_ready=1 (same-cycle drain and refill is allowed; no bubble).
- Arbitration (combinational):
  - If the register is free, grant the first i with req_valid[i]=1, scanning i = rr_ptr, rr_ptr+1, …, N_REQ-1, 0, …, rr_ptr-1.
  - req_ready[grant]=1 and all other bits are 0.
  - If the register is not free, req_ready=0.
- The mux selects req_posit of the granted requester into the shared decoder. The decoder output is registered on the handshake edge, so latency is 1 cycle from accept to out_valid.
- On accept:
  - out_valid<=1 and out_id<=grant; the result fields are loaded from the decoder.
  - rr_ptr<=(grant+1) mod N_REQ.
- Registered outputs when no accept:
  - Drain with no new grant: out_valid<=0 and the fields hold their last values.
  - Not draining: all registered outputs hold, so out_valid and every out_* field are stable while out_valid && !out_ready.
- rr_ptr changes only on accept; idle cycles never move the pointer.
- decode_count increments by 1 on each cycle with out_valid && out_ready, and wraps 0xFFFF_FFFF -> 0.
- A requester may deassert req_valid without a grant. The arbiter holds no per-requester state besides rr_ptr.
- Reset mid-transaction discards the held result; no output handshake is reported and decode_count=0.
- Throughput: 1 decode per cycle when out_ready is held high.
- Special posits (zero 0x0, NaR 0x8000_0000_0000_0000) are passed through the decoder unchanged. The arbiter does not interpret them.

Test Plan:
- Reset release, all req_valid=0, 10 cycles -> out_valid=0, req_ready=0, decode_count=0, rr_ptr=0.
- N_REQ=4, all four valid continuously, out_ready=1, requester i posit=0x4000_0000_0000_0000+i:
  - grants cycle 0,1,2,3,0,…;
  - out_id follows one cycle later;
  - fields match a standalone posit64_decode (es=2) model;
  - after 8 results, decode_count=8.
- Backpressure: out_ready=0 after first accept from requester 2 -> out_valid=1, out_id=2 and fields stable for 5 cycles, req_ready=0; release out_ready -> same-cycle accept of next requester (3), no bubble.
- Idle pointer: accept from requester 1, then 3 idle cycles, then req_valid=4'b0011 -> requester 0 granted (pointer at 2 wraps to 0), not requester 1.
- Async reset asserted mid-cycle while out_valid=1 and out_ready=0 -> out_valid, decode_count, rr_ptr and all out_* fields 0 immediately, before the next clk edge.
- Counter wrap: force decode_count to 0xFFFF_FFFF via backdoor and complete one handshake -> decode_count=0; NaR input 0x8000_0000_0000_0000 -> out_sign matches reference decoder.
